stack_ctrl: RTL and testbench
=============================

STACK_CTRL -- requirements
Module: stack_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning number of 8-bit stack entries (fixed at 16; address width 4).
REQ-002 SHALL have parameter DW, default 8, meaning data width.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 cmd_valid  input  1  command request.
REQ-006 cmd_op  input  2  operation: 00 PUSH, 01 POP, 10 PEEK, 11 CLEAR.
REQ-007 cmd_wdata  input  8  data to push.
REQ-008 cmd_ready  output  1  controller can accept a command.
REQ-009 rsp_valid  output  1  one-cycle completion pulse.
REQ-010 rsp_err  output  1  qualifies rsp_valid: overflow or underflow, no memory access made.
REQ-011 rsp_data  output  8  POP/PEEK result, held until the next POP/PEEK completion.
REQ-012 level  output  5  current entry count, 0..16.
REQ-013 full / empty  output  1 each  level==16 / level==0.
REQ-014 mem_sm, mem_we, mem_re  output  1 each  memory select, write enable, read enable.
REQ-015 mem_addr  output  4  memory address.
REQ-016 mem_wdata  output  8, mem_wdata_oe  output  1  write data and bus-drive enable for the top-level tristate.
REQ-017 mem_rdata  input  8  shared data bus as seen by the controller.

Function
REQ-018 SHALL implement states IDLE, PUSH, POP_RD, POP_CAP; cmd_ready=1 only in IDLE.
REQ-019 Command accepted on posedge when cmd_valid && cmd_ready; cmd_op/cmd_wdata captured at that edge.
REQ-020 PUSH with level<16: IDLE->PUSH; in PUSH drive mem_sm=1, mem_we=1, mem_addr=sp[3:0], mem_wdata=captured data, mem_wdata_oe=1 for exactly one cycle; at its end sp+=1, ->IDLE, rsp_valid=1, rsp_err=0 next cycle.
REQ-021 POP/PEEK with level>0: IDLE->POP_RD->POP_CAP; both cycles mem_sm=1, mem_re=1, mem_addr=sp-1; at end of POP_CAP capture mem_rdata into rsp_data, ->IDLE, rsp_valid=1; POP also sp-=1, PEEK leaves sp unchanged.
REQ-022 Latency accept-edge to rsp_valid: PUSH 2 cycles, POP/PEEK 3 cycles; back-to-back acceptance allowed in the cycle rsp_valid is high.
REQ-023 PUSH when full, or POP/PEEK when empty: no state change, no memory strobe, rsp_valid=1 and rsp_err=1 the next cycle, sp and rsp_data unchanged.
REQ-024 CLEAR: sp<=0 at accept edge, no memory access, rsp_valid=1, rsp_err=0 next cycle; memory contents untouched.
REQ-025 mem_we, mem_re, mem_wdata_oe SHALL never be simultaneously asserted; all mem_* strobes 0 in IDLE; mem_we and mem_wdata_oe are identical.
REQ-026 sp is 5 bits, saturating 0..16 by construction; level=sp; mem_addr uses sp[3:0] (push) or (sp-1)[3:0] (pop); no wrap-around permitted.
REQ-027 cmd_valid/cmd_op outside IDLE SHALL be ignored.
REQ-028 All outputs SHALL be registered or decoded from state/sp only; no combinational path cmd_* -> mem_*.

Reset
REQ-029 On rst_n low: state=IDLE, sp=0, rsp_valid=0, rsp_err=0, rsp_data=0, all mem_* outputs 0; full=0, empty=1, cmd_ready=1 after release.
REQ-030 Reset mid-operation aborts it: no write committed after reset assertion, no rsp_valid pulse for the aborted command.

Structure
REQ-031 Shared package stack_pkg SHALL hold DEPTH, AW=4, DW=8, op encodings and state encodings.
REQ-032 Single flat module; no sub-module; tristate merge of mem_wdata onto the memory data bus and stack_memory instantiation live at the top level.

Verification
REQ-033 Reset then PUSH 0xA5 -> mem_we=1, mem_addr=0 one cycle; rsp_valid 2 cycles after accept; level=1.
REQ-034 PUSH 0x11, 0x22, 0x33 then POP x3 -> rsp_data 0x33, 0x22, 0x11; mem_re high 2 cycles each; level returns 0, empty=1.
REQ-035 16 PUSHes then 17th PUSH -> full=1, rsp_err=1, no mem_we pulse, level stays 16; then PEEK -> rsp_data equals 16th value, level 16.
REQ-036 POP on empty -> rsp_err=1 one cycle after accept, mem_re never asserted, rsp_data unchanged.
REQ-037 3 PUSHes, CLEAR, POP -> CLEAR rsp_err=0, level=0; POP gives rsp_err=1.
REQ-038 Assert rst_n low during POP_RD -> no rsp_valid, level=0, all mem_* 0 immediately (asynchronous).

Source files
------------

// File: rtl/stack_pkg.sv
// stack_pkg: shared sizes, command encodings and controller states for the stack controller
package stack_pkg;
    localparam int DEPTH = 16;
    localparam int AW = 4;
    localparam int DW = 8;
    typedef enum logic [1:0] {OP_PUSH = 2'b00, OP_POP = 2'b01, OP_PEEK = 2'b10, OP_CLEAR = 2'b11} op_t;
    typedef enum logic [1:0] {S_IDLE, S_PUSH, S_POP_RD, S_POP_CAP} state_t;
endpackage

// File: rtl/stack_ctrl.sv
// stack_ctrl: command-driven LIFO controller sequencing a single-port external stack memory
module stack_ctrl
    import stack_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    input  logic [1:0]    cmd_op,
    input  logic [DW-1:0] cmd_wdata,
    output logic          cmd_ready,
    output logic          rsp_valid,
    output logic          rsp_err,
    output logic [DW-1:0] rsp_data,
    output logic [AW:0]   level,
    output logic          full,
    output logic          empty,
    output logic          mem_sm,
    output logic          mem_we,
    output logic          mem_re,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_wdata_oe,
    input  logic [DW-1:0] mem_rdata
);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
    state_t state_q, state_d;
    op_t op_q;
    logic [AW:0] sp_q, sp_m1;
    logic [DW-1:0] wdata_q, rsp_data_q;
    logic rsp_valid_q, rsp_err_q, accept, is_push, is_read, is_clear, bad;
    assign accept = cmd_valid && state_q == S_IDLE;
    assign is_push = cmd_op == OP_PUSH;
    assign is_read = cmd_op == OP_POP || cmd_op == OP_PEEK;
    assign is_clear = cmd_op == OP_CLEAR;
    assign bad = (is_push && full) || (is_read && empty);
    assign sp_m1 = sp_q - 1'b1;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else state_q <= state_d;
    end
    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE:   state_d = (!accept || bad) ? S_IDLE : is_push ? S_PUSH : is_read ? S_POP_RD : S_IDLE;
            S_POP_RD: state_d = S_POP_CAP;
            default:  state_d = S_IDLE;
        endcase
    end
    // Memory strobes decode from state/sp only, so cmd_* never reaches mem_* combinationally.
    always_comb begin
        cmd_ready = state_q == S_IDLE;
        mem_sm = state_q != S_IDLE;
        mem_we = state_q == S_PUSH;
        mem_re = state_q == S_POP_RD || state_q == S_POP_CAP;
        mem_wdata_oe = mem_we;
        mem_addr = mem_we ? sp_q[AW-1:0] : mem_re ? sp_m1[AW-1:0] : '0;
        mem_wdata = mem_we ? wdata_q : '0;
        level = sp_q;
        full = sp_q == FULL_LVL;
        empty = sp_q == '0;
        rsp_valid = rsp_valid_q;
        rsp_err = rsp_err_q;
        rsp_data = rsp_data_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q <= OP_PUSH;
            wdata_q <= '0;
            sp_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q <= 1'b0;
            rsp_data_q <= '0;
        end else begin
            if (accept) begin
                op_q <= op_t'(cmd_op);
                wdata_q <= cmd_wdata;
            end
            sp_q <= (accept && is_clear) ? '0 :
                    state_q == S_PUSH ? sp_q + 1'b1 :
                    (state_q == S_POP_CAP && op_q == OP_POP) ? sp_m1 : sp_q;
            rsp_valid_q <= (accept && (bad || is_clear)) || state_q == S_PUSH || state_q == S_POP_CAP;
            rsp_err_q <= accept && bad;
            if (state_q == S_POP_CAP) rsp_data_q <= mem_rdata;
        end
    end
endmodule

// File: tb/tb_stack_ctrl.sv
// tb_stack_ctrl: directed self-checking bench for stack_ctrl with a behavioural stack memory
module tb_stack_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'b00;
    logic [7:0] cmd_wdata = 8'h00;
    logic cmd_ready, rsp_valid, rsp_err, full, empty;
    logic mem_sm, mem_we, mem_re, mem_wdata_oe;
    logic [7:0] rsp_data, mem_wdata, mem_rdata;
    logic [4:0] level;
    logic [3:0] mem_addr;
    logic [7:0] mem [16];
    int checks = 0;
    int failures = 0;
    int lat, we_n, re_n, excl_bad;
    logic [3:0] waddr;

    stack_ctrl #(.DEPTH(16), .DW(8)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_wdata(cmd_wdata),
        .cmd_ready(cmd_ready), .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_data(rsp_data),
        .level(level), .full(full), .empty(empty), .mem_sm(mem_sm), .mem_we(mem_we), .mem_re(mem_re),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wdata_oe(mem_wdata_oe), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_sm && mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_sm && mem_re) mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issues one command and watches strobes until rsp_valid; lat counts negedges after the accept edge.
    task automatic do_cmd(input logic [1:0] op, input logic [7:0] d);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_wdata = d;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op = 2'b11;
        lat = 0; we_n = 0; re_n = 0; excl_bad = 0; waddr = 4'hx;
        for (int i = 1; i <= 8; i++) begin
            we_n += int'(mem_we);
            re_n += int'(mem_re);
            if ((mem_we && mem_re) || (mem_we !== mem_wdata_oe)) excl_bad++;
            if (mem_we) waddr = mem_addr;
            if (rsp_valid) begin
                lat = i;
                break;
            end
            @(negedge clk);
        end
        chk("strobe_exclusive", excl_bad, 0);
        if (lat == 0) chk("rsp_timeout", 0, 1);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        mem_rdata = 8'h00;
        #12;
        chk("rst_level", level, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_mem", {mem_sm, mem_we, mem_re, mem_wdata_oe, mem_addr}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", cmd_ready, 1);

        do_cmd(2'b00, 8'hA5);
        chk("push_lat", lat, 2);
        chk("push_we_cycles", we_n, 1);
        chk("push_addr", waddr, 0);
        chk("push_err", rsp_err, 0);
        chk("push_level", level, 1);
        chk("push_mem", mem[0], 8'hA5);

        do_cmd(2'b00, 8'h11);
        do_cmd(2'b00, 8'h22);
        do_cmd(2'b00, 8'h33);
        chk("push3_level", level, 4);
        do_cmd(2'b01, 8'h00);
        chk("pop1_lat", lat, 3);
        chk("pop1_re", re_n, 2);
        chk("pop1_data", rsp_data, 8'h33);
        do_cmd(2'b01, 8'h00);
        chk("pop2_data", rsp_data, 8'h22);
        chk("pop2_re", re_n, 2);
        do_cmd(2'b01, 8'h00);
        chk("pop3_data", rsp_data, 8'h11);
        chk("pop3_we", we_n, 0);
        do_cmd(2'b01, 8'h00);
        chk("pop4_data", rsp_data, 8'hA5);
        chk("pop4_level", level, 0);
        chk("pop4_empty", empty, 1);

        do_cmd(2'b01, 8'h00);
        chk("uf_lat", lat, 1);
        chk("uf_err", rsp_err, 1);
        chk("uf_re", re_n, 0);
        chk("uf_data", rsp_data, 8'hA5);
        chk("uf_level", level, 0);

        for (int i = 0; i < 16; i++) begin
            do_cmd(2'b00, 8'h40 + 8'(i));
            chk("fill_addr", waddr, 32'(i));
        end
        chk("fill_full", full, 1);
        chk("fill_level", level, 16);
        do_cmd(2'b00, 8'hEE);
        chk("of_lat", lat, 1);
        chk("of_err", rsp_err, 1);
        chk("of_we", we_n, 0);
        chk("of_level", level, 16);
        do_cmd(2'b10, 8'h00);
        chk("peek_lat", lat, 3);
        chk("peek_err", rsp_err, 0);
        chk("peek_data", rsp_data, 8'h4F);
        chk("peek_level", level, 16);

        do_cmd(2'b11, 8'h00);
        do_cmd(2'b00, 8'h01);
        do_cmd(2'b00, 8'h02);
        do_cmd(2'b00, 8'h03);
        chk("clr_pre_level", level, 3);
        do_cmd(2'b11, 8'h00);
        chk("clr_lat", lat, 1);
        chk("clr_err", rsp_err, 0);
        chk("clr_mem_access", we_n + re_n, 0);
        chk("clr_level", level, 0);
        chk("clr_mem_kept", mem[2], 8'h03);
        do_cmd(2'b01, 8'h00);
        chk("clr_pop_err", rsp_err, 1);

        do_cmd(2'b00, 8'h77);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op = 2'b01;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("abort_in_rd", mem_re, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_mem", {mem_sm, mem_we, mem_re, mem_wdata_oe, mem_addr, mem_wdata}, 0);
        chk("abort_level", level, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_no_rsp", rsp_valid, 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_ready", cmd_ready, 1);
        chk("abort_rsp_data", rsp_data, 0);
        do_cmd(2'b00, 8'h5A);
        chk("post_push_addr", waddr, 0);
        chk("post_level", level, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
